// File: rtl/miniRV_pkg.sv
// Shared types and constants for the miniRV front end: fetch FSM states,
// the IF/ID pipeline payload, and a word-alignment helper.
package miniRV_pkg;

    localparam int          XLEN        = 32;
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instruction;
        logic            valid;
    } if_id_t;

    // Instruction addresses are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush clears only the valid bit so the payload
// fields keep their last captured values; hold freezes everything.
module if_id_reg
    import miniRV_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   flush,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_r;

    // Priority: flush > hold > load; with none asserted the register holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
        end else if (flush) begin
            q_r.valid <= 1'b0;
        end else if (hold) begin
            q_r <= q_r;
        end else if (load) begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/fetch_pc_stage.sv
// Program counter, fetch FSM (RUN/HALTED/FAULT) and IF/ID capture for the
// miniRV core. Drives imem_addr straight from the PC register.
module fetch_pc_stage
    import miniRV_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_WORDS   = 32,
    parameter logic [31:0] EBREAK_INSN = miniRV_pkg::EBREAK_INSN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instruction,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instruction,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    // One extra bit so MEM_WORDS*4 == 2^32 would still compare correctly.
    localparam logic [XLEN:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

    fetch_state_e    state_q, state_next;
    logic [XLEN-1:0] pc_q, pc_next;
    logic [XLEN-1:0] count_q, count_next;
    logic            in_range;
    logic            is_ebreak;
    logic            ifid_hold, ifid_flush, ifid_load;
    if_id_t          ifid_d, ifid_q;

    assign in_range  = ({1'b0, pc_q} < PC_LIMIT);
    assign is_ebreak = (imem_instruction == EBREAK_INSN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_next;
            pc_q    <= pc_next;
            count_q <= count_next;
        end
    end

    always_comb begin
        state_next = state_q;
        pc_next    = pc_q;
        count_next = count_q;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;

        if (redirect_valid) begin
            pc_next    = align_word(redirect_target);
            state_next = RUN;
            ifid_flush = 1'b1;
        end else if (stall) begin
            ifid_hold = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!in_range) begin
                        state_next = FAULT;
                        ifid_flush = 1'b1;
                    end else begin
                        // EBREAK is still handed to decode, but the PC parks on it.
                        ifid_load  = 1'b1;
                        count_next = count_q + 32'd1;
                        if (is_ebreak) begin
                            state_next = HALTED;
                        end else begin
                            pc_next = pc_q + 32'd4;
                        end
                    end
                end
                HALTED, FAULT: begin
                    ifid_flush = 1'b1;
                end
                default: begin
                    state_next = RUN;
                    ifid_flush = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        ifid_d             = '0;
        ifid_d.pc          = pc_q;
        ifid_d.pc_plus4    = pc_q + 32'd4;
        ifid_d.instruction = imem_instruction;
        ifid_d.valid       = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (ifid_hold),
        .flush (ifid_flush),
        .load  (ifid_load),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_addr      = pc_q;
    assign id_valid       = ifid_q.valid;
    assign id_pc          = ifid_q.pc;
    assign id_pc_plus4    = ifid_q.pc_plus4;
    assign id_instruction = ifid_q.instruction;
    assign halted         = (state_q == HALTED);
    assign fault          = (state_q == FAULT);
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage with a 32-word combinational instruction
// memory model; every expected value below is hand-derived.
module tb_fetch_pc_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] ADDI10 = 32'h00A0_0093;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instruction;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:31];

    int n_assert = 0;
    int n_fail   = 0;

    fetch_pc_stage #(
        .RESET_PC    (32'h0000_0000),
        .MEM_WORDS   (32),
        .EBREAK_INSN (32'h0010_0073)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .id_valid         (id_valid),
        .id_pc            (id_pc),
        .id_pc_plus4      (id_pc_plus4),
        .id_instruction   (id_instruction),
        .halted           (halted),
        .fault            (fault),
        .fetch_count      (fetch_count)
    );

    // Clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instruction = mem[imem_addr[6:2]];

    // Driver helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_imem_addr"},   imem_addr,           32'h0);
        chk({tag, "_id_valid"},    {31'd0, id_valid},   32'h0);
        chk({tag, "_id_pc"},       id_pc,               32'h0);
        chk({tag, "_id_pc_plus4"}, id_pc_plus4,         32'h0);
        chk({tag, "_id_instr"},    id_instruction,      32'h0);
        chk({tag, "_halted"},      {31'd0, halted},     32'h0);
        chk({tag, "_fault"},       {31'd0, fault},      32'h0);
        chk({tag, "_count"},       fetch_count,         32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = NOP;
        mem[4] = ADDI10;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;

        // Reset state
        repeat (2) step();
        chk_reset_values("rst0");
        rst = 1'b0;

        // Free run over NOPs
        step();
        chk("run1_addr",  imem_addr,          32'h4);
        chk("run1_valid", {31'd0, id_valid},  32'h1);
        chk("run1_pc",    id_pc,              32'h0);
        chk("run1_pc4",   id_pc_plus4,        32'h4);
        chk("run1_instr", id_instruction,     NOP);
        chk("run1_count", fetch_count,        32'h1);
        step();
        chk("run2_addr",  imem_addr,          32'h8);
        chk("run2_pc",    id_pc,              32'h4);
        chk("run2_count", fetch_count,        32'h2);

        // Two-cycle stall at pc=8
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_addr",  imem_addr,         32'h8);
            chk("stall_pc",    id_pc,             32'h4);
            chk("stall_valid", {31'd0, id_valid}, 32'h1);
            chk("stall_count", fetch_count,       32'h2);
        end
        stall = 1'b0;
        step();
        chk("resume_pc",    id_pc,       32'h8);
        chk("resume_addr",  imem_addr,   32'hC);
        chk("resume_count", fetch_count, 32'h3);

        // Redirect to a misaligned target while stalled
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0013;
        step();
        stall = 1'b0;
        redirect_valid = 1'b0;
        chk("redir_addr",  imem_addr,         32'h10);
        chk("redir_valid", {31'd0, id_valid}, 32'h0);
        chk("redir_count", fetch_count,       32'h3);
        step();
        chk("redir2_valid", {31'd0, id_valid}, 32'h1);
        chk("redir2_pc",    id_pc,             32'h10);
        chk("redir2_pc4",   id_pc_plus4,       32'h14);
        chk("redir2_instr", id_instruction,    ADDI10);
        chk("redir2_addr",  imem_addr,         32'h14);
        chk("redir2_count", fetch_count,       32'h4);

        // EBREAK at address 12
        mem[3] = EBRK;
        do_reset();
        repeat (3) step();
        chk("pre_ebrk_pc", id_pc, 32'h8);
        step();
        chk("ebrk_instr",  id_instruction,    EBRK);
        chk("ebrk_pc",     id_pc,             32'hC);
        chk("ebrk_valid",  {31'd0, id_valid}, 32'h1);
        chk("ebrk_halted", {31'd0, halted},   32'h1);
        chk("ebrk_addr",   imem_addr,         32'hC);
        chk("ebrk_count",  fetch_count,       32'h4);
        step();
        chk("halt_valid",  {31'd0, id_valid}, 32'h0);
        chk("halt_halted", {31'd0, halted},   32'h1);
        chk("halt_addr",   imem_addr,         32'hC);
        chk("halt_count",  fetch_count,       32'h4);
        redirect_valid = 1'b1;
        redirect_target = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk("unhalt_halted", {31'd0, halted}, 32'h0);
        chk("unhalt_addr",   imem_addr,       32'h0);
        step();
        chk("restart_pc",    id_pc,             32'h0);
        chk("restart_valid", {31'd0, id_valid}, 32'h1);
        chk("restart_addr",  imem_addr,         32'h4);
        chk("restart_count", fetch_count,       32'h5);

        // Run off the end of memory
        mem[3] = NOP;
        do_reset();
        repeat (32) step();
        chk("end_pc",    id_pc,            32'h7C);
        chk("end_addr",  imem_addr,        32'h80);
        chk("end_fault", {31'd0, fault},   32'h0);
        chk("end_count", fetch_count,      32'h20);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("fault_flag",  {31'd0, fault},    32'h1);
            chk("fault_valid", {31'd0, id_valid}, 32'h0);
            chk("fault_addr",  imem_addr,         32'h80);
            chk("fault_count", fetch_count,       32'h20);
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_000A;
        step();
        redirect_valid = 1'b0;
        chk("unfault_flag", {31'd0, fault}, 32'h0);
        chk("unfault_addr", imem_addr,      32'h8);
        step();
        chk("unfault_pc",    id_pc,       32'h8);
        chk("unfault_count", fetch_count, 32'h21);

        // Asynchronous reset between edges at pc=20
        do_reset();
        repeat (5) step();
        chk("pre_arst_addr", imem_addr, 32'h14);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_values("arst");
        step();
        rst = 1'b0;
        step();
        chk("post_arst_pc",    id_pc,       32'h0);
        chk("post_arst_addr",  imem_addr,   32'h4);
        chk("post_arst_count", fetch_count, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
